// File: rtl/t05_arb_pkg.sv
// Shared definitions for the SRAM arbiter: FSM states, requester indices,
// and the default timeout used when T05_ARB_TIMEOUT_EN is defined.
package t05_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } arb_state_e;

    localparam int REQ_HIST  = 0;
    localparam int REQ_FLV   = 1;
    localparam int REQ_HTREE = 2;
    localparam int REQ_CBTRN = 3;

    localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/t05_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester
// found after index 'last', wrapping from NUM_REQ-1 to 0.
module t05_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] grant
);

    logic [IW:0]          start;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   rot_grant;
    logic [2*NUM_REQ-1:0] dbl_grant;

    // Rotate so the highest-priority requester sits at bit 0, pick the
    // lowest set bit, then rotate the result back.
    assign start = (last == IW'(NUM_REQ - 1)) ? '0 : {1'b0, last} + 1'b1;
    assign rot   = NUM_REQ'({req, req} >> start);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pri
        if (gi == 0) begin : g_first
            assign rot_grant[gi] = rot[0];
        end else begin : g_rest
            assign rot_grant[gi] = rot[gi] & ~(|rot[gi-1:0]);
        end
    end

    assign dbl_grant = {{NUM_REQ{1'b0}}, rot_grant} << start;
    assign grant     = dbl_grant[NUM_REQ-1:0] | dbl_grant[2*NUM_REQ-1:NUM_REQ];

endmodule

// File: rtl/t05_sram_arbiter.sv
// Round-robin arbiter feeding one wishbone_manager from NUM_REQ requesters.
// Define T05_ARB_TIMEOUT_EN to add the per-phase wait timeout and err_o.
module t05_sram_arbiter
    import t05_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   we_i,
    input  logic [NUM_REQ*32-1:0] addr_i,
    input  logic [NUM_REQ*32-1:0] wdata_i,
    input  logic [NUM_REQ*4-1:0] sel_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [NUM_REQ-1:0]   done_o,
    output logic [NUM_REQ-1:0]   err_o,
    output logic [31:0]          rdata_o,
    output logic                 wb_write_o,
    output logic                 wb_read_o,
    output logic [31:0]          wb_addr_o,
    output logic [31:0]          wb_wdata_o,
    output logic [3:0]           wb_sel_o,
    input  logic [31:0]          wb_rdata_i,
    input  logic                 wb_busy_i
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    arb_state_e         state_reg;
    logic [IW-1:0]      last_reg;
    logic [IW-1:0]      winner_reg;
    logic               we_reg;
    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0]      pick_idx;
    logic               pick_we;
    logic [31:0]        pick_addr;
    logic [31:0]        pick_wdata;
    logic [3:0]         pick_sel;
    logic               timeout;
    logic               finish;

    t05_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req   (req_i),
        .last  (last_reg),
        .grant (pick)
    );

    always_comb begin
        pick_idx   = '0;
        pick_we    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        pick_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx   = IW'(i);
                pick_we    = we_i[i];
                pick_addr  = addr_i[i*32 +: 32];
                pick_wdata = wdata_i[i*32 +: 32];
                pick_sel   = sel_i[i*4 +: 4];
            end
        end
    end

`ifdef T05_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_reg;

    // Fires at the end of the TIMEOUT_CYC-th cycle spent waiting in a phase.
    assign timeout = (cnt_reg == CW'(TIMEOUT_CYC - 1)) &&
                     (((state_reg == ST_WAIT_BUSY) && !wb_busy_i) ||
                      ((state_reg == ST_WAIT_DONE) &&  wb_busy_i));
`else
    assign timeout = 1'b0;
    assign err_o   = '0;
`endif

    assign finish = ((state_reg == ST_WAIT_DONE) && !wb_busy_i) || timeout;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg  <= ST_IDLE;
            last_reg   <= IW'(NUM_REQ - 1);
            winner_reg <= '0;
            we_reg     <= 1'b0;
            gnt_o      <= '0;
            done_o     <= '0;
            rdata_o    <= '0;
            wb_write_o <= 1'b0;
            wb_read_o  <= 1'b0;
            wb_addr_o  <= '0;
            wb_wdata_o <= '0;
            wb_sel_o   <= '0;
`ifdef T05_ARB_TIMEOUT_EN
            err_o      <= '0;
            cnt_reg    <= '0;
`endif
        end else begin
            done_o     <= '0;
            wb_write_o <= 1'b0;
            wb_read_o  <= 1'b0;
`ifdef T05_ARB_TIMEOUT_EN
            err_o <= '0;
            if (state_reg == ST_WAIT_BUSY || state_reg == ST_WAIT_DONE) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == ST_ISSUE || (state_reg == ST_WAIT_BUSY && wb_busy_i)) begin
                cnt_reg <= '0;
            end
            if (timeout) begin
                err_o <= gnt_o;
            end
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (|req_i) begin
                        gnt_o      <= pick;
                        winner_reg <= pick_idx;
                        we_reg     <= pick_we;
                        wb_write_o <= pick_we;
                        wb_read_o  <= !pick_we;
                        wb_addr_o  <= pick_addr;
                        wb_wdata_o <= pick_wdata;
                        wb_sel_o   <= pick_sel;
                        state_reg  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_reg <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (wb_busy_i) begin
                        state_reg <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!wb_busy_i) begin
                        if (!we_reg) begin
                            rdata_o <= wb_rdata_i;
                        end
                        done_o <= gnt_o;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
            // Completion and timeout share the same release path.
            if (finish) begin
                gnt_o      <= '0;
                last_reg   <= winner_reg;
                we_reg     <= 1'b0;
                wb_addr_o  <= '0;
                wb_wdata_o <= '0;
                wb_sel_o   <= '0;
                state_reg  <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Self-checking bench for t05_sram_arbiter with a simple wishbone_manager model.
module tb_t05_sram_arbiter;
    import t05_arb_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic [N-1:0]   we_i = '0;
    logic [N*32-1:0] addr_i = '0;
    logic [N*32-1:0] wdata_i = '0;
    logic [N*4-1:0] sel_i = '0;
    logic [N-1:0]   gnt_o, done_o, err_o;
    logic [31:0]    rdata_o;
    logic           wb_write_o, wb_read_o;
    logic [31:0]    wb_addr_o, wb_wdata_o;
    logic [3:0]     wb_sel_o;
    logic [31:0]    wb_rdata_i;
    logic           wb_busy_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          onehot_bad = 0;
    int          busy_len = 1;
    int          busy_cnt = 0;
    logic        busy_stuck = 1'b0;
    logic [31:0] mgr_rdata = '0;

    assign wb_rdata_i = mgr_rdata;

    t05_sram_arbiter dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .sel_i      (sel_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .wb_write_o (wb_write_o),
        .wb_read_o  (wb_read_o),
        .wb_addr_o  (wb_addr_o),
        .wb_wdata_o (wb_wdata_o),
        .wb_sel_o   (wb_sel_o),
        .wb_rdata_i (wb_rdata_i),
        .wb_busy_i  (wb_busy_i)
    );

    always #5 clk = ~clk;

    // Manager model: busy rises on the edge after a command pulse and stays high busy_len cycles.
    always @(posedge clk) begin
        if (!nrst) begin
            wb_busy_i <= 1'b0;
            busy_cnt  <= 0;
        end else if (busy_stuck) begin
            wb_busy_i <= 1'b1;
        end else if (wb_read_o || wb_write_o) begin
            wb_busy_i <= 1'b1;
            busy_cnt  <= busy_len - 1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            wb_busy_i <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (nrst === 1'b1 && ($countones(gnt_o) > 1 || $countones(done_o) > 1 ||
                              $countones(err_o) > 1)) begin
            onehot_bad <= onehot_bad + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        we_i[i]            = we;
        addr_i[i*32 +: 32] = a;
        wdata_i[i*32 +: 32] = d;
        sel_i[i*4 +: 4]    = s;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic wait_gnt(output int c, output logic [N-1:0] g);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (gnt_o == '0 && c < 100);
        g = gnt_o;
    endtask

    task automatic wait_done(output int c, output logic [N-1:0] d);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (done_o == '0 && err_o == '0 && c < 100);
        d = done_o;
    endtask

    typedef struct {
        int          idx;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          busy;
        logic [31:0] rd;
        logic [3:0]  exp_done;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vec_t        v;
        int          lat, rd_p, wr_p, stable_bad, c;
        logic [N-1:0] g, d;
        logic [N-1:0] g_first;
        logic [N-1:0] exp_order[5];

        vecs[0] = '{REQ_HIST,  1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF, 2, 32'hDEAD_BEEF, 4'b0001, 5, 32'hDEAD_BEEF};
        vecs[1] = '{REQ_HTREE, 1'b1, 32'h3000_0400, 32'h0000_00A5, 4'hF, 3, 32'h5555_5555, 4'b0100, 6, 32'hDEAD_BEEF};
        vecs[2] = '{REQ_FLV,   1'b0, 32'h1234_5678, 32'h1111_2222, 4'h3, 1, 32'hCAFE_F00D, 4'b0010, 4, 32'hCAFE_F00D};
        vecs[3] = '{REQ_CBTRN, 1'b0, 32'h3000_0FFC, 32'h0000_0000, 4'h8, 4, 32'h0102_0304, 4'b1000, 7, 32'h0102_0304};
        vecs[4] = '{REQ_CBTRN, 1'b1, 32'h3000_0800, 32'hFFFF_0000, 4'hC, 1, 32'hAAAA_AAAA, 4'b1000, 4, 32'h0102_0304};
        vecs[5] = '{REQ_HIST,  1'b0, 32'h0000_0000, 32'h0000_0000, 4'h1, 5, 32'h0000_0000, 4'b0001, 8, 32'h0000_0000};
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_cmd", {30'h0, wb_read_o, wb_write_o}, 32'h0);
        check("rst_addr", wb_addr_o, 32'h0);
        nrst = 1'b1;

        // Table-driven single-requester transactions
        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            @(negedge clk);
            set_req(v.idx, v.we, v.addr, v.wdata, v.sel);
            busy_len  = v.busy;
            mgr_rdata = v.rd;
            req_i     = '0;
            req_i[v.idx] = 1'b1;
            lat = 0; rd_p = 0; wr_p = 0; stable_bad = 0; g_first = '0;
            while (done_o == '0 && lat < 100) begin
                @(negedge clk);
                lat++;
                if (lat == 1) g_first = gnt_o;
                if (wb_read_o)  rd_p++;
                if (wb_write_o) wr_p++;
                if (gnt_o != '0 && (wb_addr_o !== v.addr || wb_wdata_o !== v.wdata ||
                                    wb_sel_o !== v.sel)) stable_bad++;
            end
            d = done_o;
            req_i = '0;
            check($sformatf("v%0d_gnt", k), 32'(g_first), 32'(v.exp_done));
            check($sformatf("v%0d_rd_pulses", k), rd_p, v.we ? 0 : 1);
            check($sformatf("v%0d_wr_pulses", k), wr_p, v.we ? 1 : 0);
            check($sformatf("v%0d_wb_hold_bad", k), stable_bad, 0);
            check($sformatf("v%0d_done", k), 32'(d), 32'(v.exp_done));
            check($sformatf("v%0d_latency", k), lat, v.exp_lat);
            check($sformatf("v%0d_rdata", k), rdata_o, v.exp_rdata);
            check($sformatf("v%0d_idle_addr", k), wb_addr_o, 32'h0);
        end

        // All four requesting from reset: order 0,1,2,3,0 with no idle gap
        do_reset();
        busy_len  = 1;
        mgr_rdata = 32'h7777_0000;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h3000_0000 + 32'(i * 4), 32'h0, 4'hF);
        req_i = '1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(c, g);
            check($sformatf("rr_order%0d", k), 32'(g), 32'(exp_order[k]));
            if (k > 0) check($sformatf("rr_gap%0d", k), c, 1);
            wait_done(c, d);
            check($sformatf("rr_done%0d", k), 32'(d), 32'(exp_order[k]));
            if (k == 4) req_i = '0;
        end

        // Requester 1 drops during WAIT_DONE; pending requester 3 follows
        @(negedge clk);
        busy_len = 4;
        req_i = 4'b1010;
        wait_gnt(c, g);
        check("drop_gnt", 32'(g), 32'h2);
        repeat (2) @(negedge clk);
        req_i[1] = 1'b0;
        @(negedge clk);
        check("drop_gnt_held", 32'(gnt_o), 32'h2);
        wait_done(c, d);
        check("drop_done", 32'(d), 32'h2);
        wait_gnt(c, g);
        check("drop_next_gnt", 32'(g), 32'h8);
        check("drop_next_gap", c, 1);
        wait_done(c, d);
        req_i = '0;

        // Reset during WAIT_DONE abandons the transaction
        @(negedge clk);
        busy_len = 6;
        req_i = 4'b0100;
        wait_gnt(c, g);
        check("rstmid_gnt", 32'(g), 32'h4);
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        check("rstmid_gnt0", 32'(gnt_o), 32'h0);
        check("rstmid_done0", 32'(done_o), 32'h0);
        check("rstmid_err0", 32'(err_o), 32'h0);
        check("rstmid_rdata0", rdata_o, 32'h0);
        check("rstmid_cmd0", {30'h0, wb_read_o, wb_write_o}, 32'h0);
        check("rstmid_addr0", wb_addr_o, 32'h0);
        check("rstmid_wdata0", wb_wdata_o, 32'h0);
        check("rstmid_sel0", 32'(wb_sel_o), 32'h0);
        req_i = '1;
        @(negedge clk);
        nrst = 1'b1;
        wait_gnt(c, g);
        check("rstmid_first_gnt", 32'(g), 32'h1);
        req_i = 4'b0001;
        wait_done(c, d);
        check("rstmid_first_done", 32'(d), 32'h1);
        req_i = '0;

        // Single persistent requester is re-granted back-to-back
        @(negedge clk);
        busy_len = 2;
        req_i = 4'b0100;
        wait_gnt(c, g);
        check("b2b_gnt0", 32'(g), 32'h4);
        wait_done(c, d);
        wait_gnt(c, g);
        check("b2b_gnt1", 32'(g), 32'h4);
        check("b2b_gap", c, 1);
        wait_done(c, d);
        req_i = '0;

        // Manager busy stuck high
        @(negedge clk);
        busy_stuck = 1'b1;
        req_i = 4'b0010;
        wait_gnt(c, g);
        check("stuck_gnt", 32'(g), 32'h2);
`ifdef T05_ARB_TIMEOUT_EN
        req_i = 4'b1010;
        c = 0;
        while (err_o == '0 && done_o == '0 && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("tmo_err", 32'(err_o), 32'h2);
        check("tmo_done", 32'(done_o), 32'h0);
        check("tmo_cycles", c, 257);
        req_i[1] = 1'b0;
        busy_stuck = 1'b0;
        wait_gnt(c, g);
        check("tmo_next_gnt", 32'(g), 32'h8);
        wait_done(c, d);
        check("tmo_next_done", 32'(d), 32'h8);
        req_i = '0;
`else
        begin
            int err_seen, done_seen, gnt_lost;
            err_seen = 0; done_seen = 0; gnt_lost = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (err_o != '0) err_seen++;
                if (done_o != '0) done_seen++;
                if (gnt_o != 4'b0010) gnt_lost++;
            end
            check("stuck_err_seen", err_seen, 0);
            check("stuck_done_seen", done_seen, 0);
            check("stuck_gnt_lost", gnt_lost, 0);
            busy_stuck = 1'b0;
            wait_done(c, d);
            check("stuck_release_done", 32'(d), 32'h2);
            req_i = '0;
        end
`endif

        repeat (2) @(negedge clk);
        check("onehot_violations", onehot_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/t05_sram_arbiter.md
T05_SRAM_ARBITER -- requirements
Module: t05_sram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (index 0 = histogram, 1 = FLV, 2 = hTree, 3 = CB/TRN).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, maximum wait cycles per phase (used only with the macro).
REQ-003 SHALL have one clock; reset is synchronous and active-low.
- clk  in  1  system clock.
- nrst  in  1  synchronous active-low reset.
REQ-004 Requester-side ports, packed with requester i at bits [i*W +: W]:
- req_i  in  NUM_REQ  request, held until done_o/err_o.
- we_i  in  NUM_REQ  1 = write, 0 = read.
- addr_i  in  NUM_REQ*32  byte address.
- wdata_i  in  NUM_REQ*32  write data.
- sel_i  in  NUM_REQ*4  byte selects.
- gnt_o  out  NUM_REQ  one-hot grant.
- done_o  out  NUM_REQ  1-cycle completion pulse.
- err_o  out  NUM_REQ  1-cycle timeout pulse.
- rdata_o  out  32  read data, valid with done_o.
REQ-005 Manager-side ports, to wishbone_manager:
- wb_write_o  out  1  WRITE_I.
- wb_read_o  out  1  READ_I.
- wb_addr_o  out  32  ADR_I.
- wb_wdata_o  out  32  CPU_DAT_I.
- wb_sel_o  out  4  SEL_I.
- wb_rdata_i  in  32  CPU_DAT_O.
- wb_busy_i  in  1  BUSY_O.

Function
REQ-006 SHALL implement FSM IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
REQ-007 IDLE: if any req_i is set, pick a winner round-robin, starting from the index after last_winner and wrapping at NUM_REQ-1 -> 0. Latch the winner's we/addr/wdata/sel, set gnt_o one-hot, go to ISSUE. If no req_i is set, stay in IDLE.
REQ-008 ISSUE: assert wb_write_o (we = 1) or wb_read_o (we = 0) for exactly one cycle, then go to WAIT_BUSY.
REQ-009 wb_addr_o, wb_wdata_o and wb_sel_o SHALL come from the latched registers and stay stable from ISSUE until return to IDLE. They are 0 in IDLE.
REQ-010 WAIT_BUSY: when wb_busy_i = 1, go to WAIT_DONE.
REQ-011 WAIT_DONE: when wb_busy_i = 0, capture wb_rdata_i into rdata_o (reads only; writes leave rdata_o unchanged), pulse done_o[winner] for one cycle, clear gnt_o, update last_winner, go to IDLE.
REQ-012 Request-to-done latency SHALL be 3 cycles plus the manager busy duration.
REQ-013 The next arbitration SHALL occur in the cycle after done_o, with no idle cycle beyond IDLE.
REQ-014 Requests that arrive or drop while a grant is active SHALL NOT alter the active transaction. A winner deasserting req_i mid-transaction still completes.
REQ-015 Simultaneous requests: each requester is served at most once per NUM_REQ grants. A requester that is continuously asserted waits at most NUM_REQ-1 transactions.
REQ-016 A single persistent requester SHALL be re-granted back-to-back.
REQ-017 At most one bit of gnt_o, done_o and err_o SHALL be high in any cycle.

Reset
REQ-018 nrst = 0 at a clock edge SHALL force:
- state = IDLE, last_winner = NUM_REQ-1 (so requester 0 wins first);
- all outputs = 0, latched registers = 0, timeout counter = 0.
REQ-019 Reset mid-transaction SHALL abandon it without a done_o or err_o pulse. The manager is reset by the same reset.

Configuration
REQ-020 With T05_ARB_TIMEOUT_EN defined:
- a counter SHALL clear on entry to WAIT_BUSY and WAIT_DONE and increment each cycle in those states;
- when it reaches TIMEOUT_CYC, pulse err_o[winner] (no done_o), clear gnt_o, update last_winner, go to IDLE.
REQ-021 Without T05_ARB_TIMEOUT_EN: no counter SHALL be built, err_o SHALL be tied to 0, and the wait states SHALL wait indefinitely.

Structure
REQ-022 The shared package t05_arb_pkg SHALL hold the FSM state enum, the requester index constants (REQ_HIST, REQ_FLV, REQ_HTREE, REQ_CBTRN) and the default TIMEOUT_CYC.
REQ-023 Round-robin winner selection SHALL be a combinational sub-module, t05_rr_pick (inputs: req, last; output: one-hot grant).

Verification
REQ-024 Bench SHALL use a wishbone_manager model with configurable busy length and cover:
- Single read: req_i = 4'b0001, addr 0x3000_0010, busy 2 cycles, wb_rdata_i = 0xDEAD_BEEF -> wb_read_o pulses 1 cycle; done_o = 4'b0001 and rdata_o = 0xDEAD_BEEF at cycle 5 after busy.
- All four requesting from reset -> grant order 0, 1, 2, 3, then 0; no overlap of gnt_o bits.
- Write from requester 2: addr 0x3000_0400, data 0x0000_00A5, sel 4'hF -> wb_write_o 1 cycle with those values stable until done_o = 4'b0100; rdata_o unchanged.
- Requester 1 drops req_i during WAIT_DONE -> transaction completes, done_o[1] pulses; requester 3 (pending) is granted next.
- nrst = 0 during WAIT_DONE -> next cycle all outputs are 0, state is IDLE, no done_o; afterwards requester 0 is granted first.
- With T05_ARB_TIMEOUT_EN and wb_busy_i stuck at 1 -> err_o[winner] pulses after 255 cycles in WAIT_DONE, then the next requester is granted. Without the macro -> the arbiter stays in WAIT_DONE and err_o stays 0.
